// File: rtl/godson_rst_seq.sv
// Multi-domain reset sequencer: PLL-lock filter, power-on delay, staged domain release,
// per-domain soft reset, lock-loss recovery with loss counter, and a mode-coded heartbeat.
module godson_rst_seq #(
  parameter int NUM_DOM      = 3,
  parameter int CNT_W        = 26,
  parameter int POR_CYCLES   = 40000000,
  parameter int STAGE_CYCLES = 1024,
  parameter int LOCK_FILT    = 8,
  parameter int SOFT_MIN     = 16,
  parameter int HB_BIT       = 21
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic [NUM_DOM-1:0] soft_req,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               all_ready,
  output logic [2:0]         state,
  output logic               heartbeat,
  output logic [7:0]         lock_lost_cnt
);

  localparam int IDX_W  = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int FILT_W = $clog2(LOCK_FILT + 1);
  localparam int SOFT_W = $clog2(SOFT_MIN + 1);

  localparam logic [CNT_W-1:0]  POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DOM - 1);
  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(LOCK_FILT - 1);
  localparam logic [SOFT_W-1:0] SOFT_LAST  = SOFT_W'(SOFT_MIN - 1);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_POR   = 3'd2,
    S_REL   = 3'd3,
    S_RUN   = 3'd4,
    S_LOST  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               lk_m, lk_s;
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic               lock_ok;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic [NUM_DOM-1:0] soft_act_q, soft_act_d;
  logic [SOFT_W-1:0]  soft_cnt_q [NUM_DOM];
  logic [SOFT_W-1:0]  soft_cnt_d [NUM_DOM];
  logic [7:0]         lost_cnt_q, lost_cnt_d;
  logic               lost;
  logic               all_ready_q, all_ready_d;
  logic [HB_BIT:0]    hb_cnt_q;
  logic               hb_q, hb_d;

  // Lock counts as qualified on the LOCK_FILT-th consecutive synced-high cycle.
  assign lock_ok = lk_s && (filt_q >= FILT_LAST);

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    idx_d      = idx_q;
    dom_d      = dom_q;
    soft_act_d = soft_act_q;
    soft_cnt_d = soft_cnt_q;
    lost_cnt_d = lost_cnt_q;
    lost       = 1'b0;
    filt_d     = filt_q;

    case (state_q)
      S_RESET: begin
        dom_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        dom_d = '0;
        if (lock_ok) begin
          state_d = S_POR;
          dly_d   = '0;
        end
      end
      S_POR: begin
        if (!lk_s) begin
          lost = 1'b1;
        end else if (dly_q == POR_LAST) begin
          dom_d[0] = 1'b1;
          idx_d    = '0;
          dly_d    = '0;
          state_d  = (NUM_DOM == 1) ? S_RUN : S_REL;
        end else begin
          dly_d = dly_q + CNT_W'(1);
        end
      end
      S_REL: begin
        if (!lk_s) begin
          lost = 1'b1;
        end else if (dly_q == STAGE_LAST) begin
          idx_d        = idx_q + IDX_W'(1);
          dom_d[idx_d] = 1'b1;
          dly_d        = '0;
          if (idx_d == IDX_LAST) state_d = S_RUN;
        end else begin
          dly_d = dly_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!lk_s) begin
          lost = 1'b1;
        end else begin
          // Each domain holds until its request is gone and SOFT_MIN low cycles have passed.
          for (int i = 0; i < NUM_DOM; i++) begin
            if (soft_act_q[i]) begin
              if ((soft_cnt_q[i] >= SOFT_LAST) && !soft_req[i]) begin
                soft_act_d[i] = 1'b0;
              end else if (soft_cnt_q[i] < SOFT_LAST) begin
                soft_cnt_d[i] = soft_cnt_q[i] + SOFT_W'(1);
              end
            end else if (soft_req[i]) begin
              soft_act_d[i] = 1'b1;
              soft_cnt_d[i] = '0;
            end
          end
          dom_d = ~soft_act_d;
        end
      end
      default: begin
        // S_LOST and the unused encodings 6/7.
        dom_d      = '0;
        soft_act_d = '0;
        state_d    = S_WAIT;
      end
    endcase

    if (lost) begin
      state_d    = S_LOST;
      dom_d      = '0;
      soft_act_d = '0;
      for (int i = 0; i < NUM_DOM; i++) soft_cnt_d[i] = '0;
      if (lost_cnt_q != 8'hFF) lost_cnt_d = lost_cnt_q + 8'd1;
    end

    if (lost || !lk_s) begin
      filt_d = '0;
    end else if (filt_q < FILT_LAST) begin
      filt_d = filt_q + FILT_W'(1);
    end
  end

  assign all_ready_d = (state_q == S_RUN) && (state_d == S_RUN) && (&dom_d);
  assign hb_d        = (state_q == S_RUN) ? hb_cnt_q[HB_BIT] : hb_cnt_q[HB_BIT-2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RESET;
      lk_m        <= 1'b0;
      lk_s        <= 1'b0;
      filt_q      <= '0;
      dly_q       <= '0;
      idx_q       <= '0;
      dom_q       <= '0;
      soft_act_q  <= '0;
      for (int i = 0; i < NUM_DOM; i++) soft_cnt_q[i] <= '0;
      lost_cnt_q  <= '0;
      all_ready_q <= 1'b0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lk_m        <= pll_lock;
      lk_s        <= lk_m;
      filt_q      <= filt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
      dom_q       <= dom_d;
      soft_act_q  <= soft_act_d;
      for (int i = 0; i < NUM_DOM; i++) soft_cnt_q[i] <= soft_cnt_d[i];
      lost_cnt_q  <= lost_cnt_d;
      all_ready_q <= all_ready_d;
      hb_cnt_q    <= hb_cnt_q + (HB_BIT+1)'(1);
      hb_q        <= hb_d;
    end
  end

  assign dom_rst_n     = dom_q;
  assign all_ready     = all_ready_q;
  assign state         = state_q;
  assign heartbeat     = hb_q;
  assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_godson_rst_seq.sv
// Directed bench for godson_rst_seq: staged release, lock filter, lock loss,
// soft reset windows, async reset and loss-counter saturation.
module tb_godson_rst_seq;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic [2:0] soft_req = 3'b000;
  logic [2:0] dom_rst_n;
  logic       all_ready;
  logic [2:0] state;
  logic       heartbeat;
  logic [7:0] lock_lost_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int ecnt;
  logic [3:0] exp_q[$];

  godson_rst_seq #(
    .NUM_DOM(3), .CNT_W(26), .POR_CYCLES(100), .STAGE_CYCLES(10),
    .LOCK_FILT(4), .SOFT_MIN(8), .HB_BIT(4)
  ) dut (
    .clock(clock), .reset(reset), .pll_lock(pll_lock), .soft_req(soft_req),
    .dom_rst_n(dom_rst_n), .all_ready(all_ready), .state(state),
    .heartbeat(heartbeat), .lock_lost_cnt(lock_lost_cnt)
  );

  // clock / reset-relative edge counter
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Park on the falling edge that follows rising edge k after reset release.
  task automatic wait_edge(input int k);
    while (ecnt < k) @(negedge clock);
  endtask

  task automatic do_reset(input logic lock);
    reset    = 1'b1;
    soft_req = 3'b000;
    pll_lock = lock;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int to_cnt;
    int k;
    logic [3:0] e;

    // Run 1: reset values, then steady lock through to S_RUN
    pll_lock = 1'b1;
    @(negedge clock);
    check("rst_dom", 8'(dom_rst_n), 8'h00);
    check("rst_ready", 8'(all_ready), 8'h00);
    check("rst_state", 8'(state), 8'h00);
    check("rst_hb", 8'(heartbeat), 8'h00);
    check("rst_lost", lock_lost_cnt, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    wait_edge(1);   check("r1_wait", 8'(state), 8'h01);
    wait_edge(5);   check("r1_wait5", 8'(state), 8'h01);
                    check("r1_hb_fast1", 8'(heartbeat), 8'h01);
    wait_edge(6);   check("r1_por", 8'(state), 8'h02);
                    check("r1_por_dom", 8'(dom_rst_n), 8'h00);
    wait_edge(9);   check("r1_hb_fast0", 8'(heartbeat), 8'h00);
    wait_edge(105); check("r1_dom_pre", 8'(dom_rst_n), 8'h00);
                    check("r1_state_pre", 8'(state), 8'h02);
    wait_edge(106); check("r1_dom0", 8'(dom_rst_n), 8'h01);
                    check("r1_rel", 8'(state), 8'h03);
    wait_edge(115); check("r1_dom0_hold", 8'(dom_rst_n), 8'h01);
    wait_edge(116); check("r1_dom1", 8'(dom_rst_n), 8'h03);
    wait_edge(125); check("r1_dom1_hold", 8'(dom_rst_n), 8'h03);
    wait_edge(126); check("r1_dom2", 8'(dom_rst_n), 8'h07);
                    check("r1_run", 8'(state), 8'h04);
                    check("r1_ready_early", 8'(all_ready), 8'h00);
    wait_edge(127); check("r1_ready", 8'(all_ready), 8'h01);
                    check("r1_hb_slow_a", 8'(heartbeat), 8'h01);
    wait_edge(128); check("r1_hb_slow_b", 8'(heartbeat), 8'h01);
    wait_edge(129); check("r1_hb_slow_c", 8'(heartbeat), 8'h00);

    // Run 2: short lock pulse rejected, later full run qualifies
    do_reset(1'b0);
    wait_edge(9);   pll_lock = 1'b1;
    wait_edge(12);  pll_lock = 1'b0;
    wait_edge(13);  check("r2_pulse_a", 8'(state), 8'h01);
    wait_edge(16);  check("r2_pulse_b", 8'(state), 8'h01);
    wait_edge(20);  check("r2_pulse_c", 8'(state), 8'h01);
                    check("r2_pulse_dom", 8'(dom_rst_n), 8'h00);
    wait_edge(24);  pll_lock = 1'b1;
    wait_edge(29);  check("r2_qual_pre", 8'(state), 8'h01);
    wait_edge(30);  check("r2_qual", 8'(state), 8'h02);
    wait_edge(130); check("r2_dom0", 8'(dom_rst_n), 8'h01);
    wait_edge(140); check("r2_dom1", 8'(dom_rst_n), 8'h03);
    wait_edge(150); check("r2_dom2", 8'(dom_rst_n), 8'h07);
    wait_edge(151); check("r2_ready", 8'(all_ready), 8'h01);

    // 1-cycle soft_req[1]: domain 1 low for exactly 8 cycles
    wait_edge(160); soft_req = 3'b010;
    wait_edge(161); soft_req = 3'b000;
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 3'b101});
    exp_q.push_back({1'b1, 3'b111});
    k = 161;
    while (exp_q.size() > 0) begin
      wait_edge(k);
      e = exp_q.pop_front();
      check("soft1_dom", 8'(dom_rst_n), 8'(e[2:0]));
      check("soft1_ready", 8'(all_ready), 8'(e[3]));
      k++;
    end

    // 20-cycle soft_req[0] alongside 1-cycle soft_req[2]
    wait_edge(180); soft_req = 3'b101;
    for (int i = 0; i < 8; i++)  exp_q.push_back({1'b0, 3'b010});
    for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, 3'b110});
    exp_q.push_back({1'b1, 3'b111});
    k = 181;
    while (exp_q.size() > 0) begin
      wait_edge(k);
      if (k == 181) soft_req = 3'b001;
      if (k == 200) soft_req = 3'b000;
      e = exp_q.pop_front();
      check("soft02_dom", 8'(dom_rst_n), 8'(e[2:0]));
      check("soft02_ready", 8'(all_ready), 8'(e[3]));
      k++;
    end

    // Lock loss in S_RUN, then relock and repeat the sequence
    wait_edge(210); pll_lock = 1'b0;
    wait_edge(212); check("loss_pre_state", 8'(state), 8'h04);
                    check("loss_pre_dom", 8'(dom_rst_n), 8'h07);
    wait_edge(213); check("loss_state", 8'(state), 8'h05);
                    check("loss_dom", 8'(dom_rst_n), 8'h00);
                    check("loss_ready", 8'(all_ready), 8'h00);
                    check("loss_cnt", lock_lost_cnt, 8'h01);
    wait_edge(214); check("loss_wait", 8'(state), 8'h01);
    wait_edge(220); pll_lock = 1'b1;
    wait_edge(225); check("relock_pre", 8'(state), 8'h01);
    wait_edge(226); check("relock_por", 8'(state), 8'h02);
    wait_edge(326); check("relock_dom0", 8'(dom_rst_n), 8'h01);
    wait_edge(330); soft_req = 3'b001;
    wait_edge(331); soft_req = 3'b000;
                    check("soft_ignored", 8'(dom_rst_n), 8'h01);
    wait_edge(336); check("relock_dom1", 8'(dom_rst_n), 8'h03);
    wait_edge(346); check("relock_dom2", 8'(dom_rst_n), 8'h07);
    wait_edge(347); check("relock_ready", 8'(all_ready), 8'h01);
                    check("relock_cnt", lock_lost_cnt, 8'h01);

    // Run 3: 300 lock losses saturate the counter
    do_reset(1'b0);
    to_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b1;
      k = 0;
      while (state !== 3'd2 && k < 30) begin @(negedge clock); k++; end
      if (state !== 3'd2) to_cnt++;
      pll_lock = 1'b0;
      k = 0;
      while (state !== 3'd1 && k < 30) begin @(negedge clock); k++; end
      if (state !== 3'd1) to_cnt++;
      if (i == 99) check("lost_cnt_100", lock_lost_cnt, 8'd100);
    end
    check("loss_timeouts", 8'(to_cnt), 8'h00);
    check("lost_cnt_sat", lock_lost_cnt, 8'hFF);

    // Async reset mid-S_REL with no clock edge
    pll_lock = 1'b1;
    k = 0;
    while (state !== 3'd3 && k < 200) begin @(negedge clock); k++; end
    check("mid_rel_state", 8'(state), 8'h03);
    check("mid_rel_dom", 8'(dom_rst_n), 8'h01);
    #2 reset = 1'b1;
    #1;
    check("async_dom", 8'(dom_rst_n), 8'h00);
    check("async_state", 8'(state), 8'h00);
    check("async_ready", 8'(all_ready), 8'h00);
    check("async_hb", 8'(heartbeat), 8'h00);
    check("async_cnt", lock_lost_cnt, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
